// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - sequential signed multiply/divide unit feeding HI/LO
// One shift-add or restoring-divide iteration per cycle, then a sign-fix cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_ZERO} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   op_div_q, op_div_d;
  logic                   sign_q, sign_d;
  logic                   rsign_q, rsign_d;
  logic [WIDTH-1:0]       opnd_q, opnd_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]       hi_q, hi_d, lo_q, lo_d;
  logic                   done_q, done_d, div_zero_q, div_zero_d;

  logic [WIDTH-1:0]       a_mag, b_mag;
  logic [WIDTH:0]         mul_sum;
  logic [WIDTH:0]         rem_sh, trial;
  logic [2*WIDTH-1:0]     prod_signed;

  // Magnitudes fit in WIDTH unsigned bits, including the most negative operand.
  assign a_mag = a_in[WIDTH-1] ? -a_in : a_in;
  assign b_mag = b_in[WIDTH-1] ? -b_in : b_in;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
  assign trial   = rem_sh - {1'b0, opnd_q};
  assign prod_signed = sign_q ? -acc_q : acc_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_div_d   = op_div_q;
    sign_d     = sign_q;
    rsign_d    = rsign_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_mult) begin
          op_div_d = 1'b0;
          sign_d   = a_in[WIDTH-1] ^ b_in[WIDTH-1];
          opnd_d   = a_mag;
          acc_d    = {{WIDTH{1'b0}}, b_mag};
          cnt_d    = '0;
          state_d  = S_RUN;
        end else if (start_div) begin
          if (b_in == '0) begin
            state_d = S_ZERO;
          end else begin
            op_div_d = 1'b1;
            sign_d   = a_in[WIDTH-1] ^ b_in[WIDTH-1];
            rsign_d  = a_in[WIDTH-1];
            opnd_d   = b_mag;
            acc_d    = {{WIDTH{1'b0}}, a_mag};
            cnt_d    = '0;
            state_d  = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (!op_div_q) begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end else if (!trial[WIDTH]) begin
          acc_d = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CNT_W'(WIDTH-1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (op_div_q) begin
          lo_d = sign_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = rsign_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          hi_d = prod_signed[2*WIDTH-1:WIDTH];
          lo_d = prod_signed[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ZERO: begin
        done_d     = 1'b1;
        div_zero_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_div_q   <= 1'b0;
      sign_q     <= 1'b0;
      rsign_q    <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_div_q   <= op_div_d;
      sign_q     <= sign_d;
      rsign_q    <= rsign_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = (state_q == S_RUN) || (state_q == S_FIX);
  assign done     = done_q;
  assign div_zero = div_zero_q;

endmodule
